// File: rtl/nios2_div_pkg.sv
// Shared definitions for the iterative divider cell.
// Holds the default data width, the iteration-counter width and the FSM state encoding.
package nios2_div_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CNT_W      = $clog2(DATA_W_DEF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage : nios2_div_pkg

// File: rtl/nios2_div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   rem_in  - partial remainder before this step
//   dbit    - next dividend bit shifted in (MSB first)
//   dsr     - divisor magnitude
//   rem_out - partial remainder after the trial subtract
//   qbit    - quotient bit produced by this step
module nios2_div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic              dbit,
   input  logic [DATA_W-1:0] dsr,
   output logic [DATA_W-1:0] rem_out,
   output logic              qbit
);

   logic [DATA_W:0] shifted;

   // The shifted remainder needs one extra bit; the compare is DATA_W+1 wide.
   // When the subtract succeeds the true difference fits in DATA_W bits,
   // so the modulo-2^DATA_W subtraction below is exact.
   always_comb begin
      shifted = {rem_in, dbit};
      qbit    = (shifted >= {1'b0, dsr});
      rem_out = qbit ? (shifted[DATA_W-1:0] - dsr) : shifted[DATA_W-1:0];
   end

endmodule : nios2_div_step

// File: rtl/nios2_div_cell.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per clock.
// Ports:
//   clk, reset_n                 - clock and async active-low reset
//   A_div_src1 / A_div_src2      - dividend / divisor, captured on accepted start
//   A_div_signed                 - two's-complement operands when high
//   A_div_start                  - request pulse, taken only when idle
//   A_div_busy                   - operation in flight
//   A_div_done                   - one-cycle completion pulse
//   A_div_quot / A_div_rem       - results, held until the next completion
module nios2_div_cell
   import nios2_div_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] A_div_src1,
   input  logic [DATA_W-1:0] A_div_src2,
   input  logic              A_div_signed,
   input  logic              A_div_start,
   output logic              A_div_busy,
   output logic              A_div_done,
   output logic [DATA_W-1:0] A_div_quot,
   output logic [DATA_W-1:0] A_div_rem
);

   localparam int unsigned CTR_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   div_state_e        state_q, state_d;
   logic [CTR_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              div0_q, div0_d;
   logic              busy_d, done_d;
   logic [DATA_W-1:0] quot_d, rem_o_d;

   logic [DATA_W-1:0] step_rem;
   logic              step_qbit;
   logic              s1_neg, s2_neg;

   nios2_div_step #(.DATA_W(DATA_W)) u_step (
      .rem_in  (rem_q),
      .dbit    (dvd_q[DATA_W-1]),
      .dsr     (dsr_q),
      .rem_out (step_rem),
      .qbit    (step_qbit)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      div0_d  = div0_q;
      done_d  = 1'b0;
      quot_d  = A_div_quot;
      rem_o_d = A_div_rem;
      s1_neg  = A_div_signed & A_div_src1[DATA_W-1];
      s2_neg  = A_div_signed & A_div_src2[DATA_W-1];

      unique case (state_q)
         ST_IDLE: begin
            if (A_div_start) begin
               state_d = ST_CALC;
               cnt_d   = CTR_W'(DATA_W - 1);
               rem_d   = '0;
               div0_d  = (A_div_src2 == '0);
               q_neg_d = s1_neg ^ s2_neg;
               r_neg_d = s1_neg;
               dsr_d   = s2_neg ? (DATA_W'(0) - A_div_src2) : A_div_src2;
               // Divide-by-zero keeps the raw dividend so the remainder comes out unchanged.
               dvd_d   = (s1_neg && (A_div_src2 != '0)) ? (DATA_W'(0) - A_div_src1)
                                                        : A_div_src1;
            end
         end
         ST_CALC: begin
            // Quotient bits shift into the dividend register as its bits are consumed.
            rem_d = step_rem;
            dvd_d = {dvd_q[DATA_W-2:0], step_qbit};
            cnt_d = cnt_q - CTR_W'(1);
            if (cnt_q == '0) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            quot_d  = (q_neg_q && !div0_q) ? (DATA_W'(0) - dvd_q) : dvd_q;
            rem_o_d = (r_neg_q && !div0_q) ? (DATA_W'(0) - rem_q) : rem_q;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         dsr_q      <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         div0_q     <= 1'b0;
         A_div_busy <= 1'b0;
         A_div_done <= 1'b0;
         A_div_quot <= '0;
         A_div_rem  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dsr_q      <= dsr_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         div0_q     <= div0_d;
         A_div_busy <= busy_d;
         A_div_done <= done_d;
         A_div_quot <= quot_d;
         A_div_rem  <= rem_o_d;
      end
   end

endmodule : nios2_div_cell

// File: tb/tb_nios2_div_cell.sv
// Directed bench for nios2_div_cell: vector table plus busy-restart, back-to-back and reset sequences.
// Edge numbering: the accepting rising edge is edge 0; a value sampled on the falling
// edge after edge k is the value presented at edge k+1.
module tb_nios2_div_cell;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] src1, src2;
   logic         sgn, start;
   logic         busy, done;
   logic [W-1:0] quot, rem;

   int n_chk  = 0;
   int n_fail = 0;

   nios2_div_cell #(.DATA_W(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .A_div_src1   (src1),
      .A_div_src2   (src2),
      .A_div_signed (sgn),
      .A_div_start  (start),
      .A_div_busy   (busy),
      .A_div_done   (done),
      .A_div_quot   (quot),
      .A_div_rem    (rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive a start pulse covering exactly one rising edge; returns on the following falling edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      src1  = a;
      src2  = b;
      sgn   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the falling edge after the accept edge. Optionally re-pulses start after edge poke_k.
   task automatic wait_done(input int poke_k, output int done_at, output int busy_cnt,
                            output logic [W-1:0] q, output logic [W-1:0] r);
      int k;
      k        = 0;
      done_at  = -1;
      busy_cnt = 0;
      q        = '0;
      r        = '0;
      forever begin
         if (busy) busy_cnt++;
         if (done) begin
            done_at = k + 1;
            q       = quot;
            r       = rem;
            break;
         end
         if (k > 80) begin
            chk("done_timeout", 64'd0, 64'd1);
            break;
         end
         if (k == poke_k) begin
            src1  = 32'h0000_0009;
            src2  = 32'h0000_0003;
            sgn   = 1'b1;
            start = 1'b1;
         end else if (k == poke_k + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
   endtask

   int           done_at, busy_cnt, done_seen;
   logic [W-1:0] q, r;

   initial begin
      vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
      vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h7FFF_FFFC, 32'h0000_0001};
      vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000};
      vecs[4]  = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678};
      vecs[5]  = '{32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678};
      vecs[6]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5};
      vecs[7]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1};
      vecs[8]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE};
      vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000};
      vecs[10] = '{32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         32'd0};

      reset_n = 1'b0;
      src1    = '0;
      src2    = '0;
      sgn     = 1'b0;
      start   = 1'b0;
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_quot", 64'(quot), 64'd0);
      chk("reset_rem",  64'(rem),  64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors: result, latency, busy window, single-cycle done, hold.
      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_done(-10, done_at, busy_cnt, q, r);
         chk($sformatf("v%0d_quot", i),    64'(q),        64'(vecs[i].q));
         chk($sformatf("v%0d_rem", i),     64'(r),        64'(vecs[i].r));
         chk($sformatf("v%0d_done_at", i), 64'(done_at),  64'd34);
         chk($sformatf("v%0d_busy_n", i),  64'(busy_cnt), 64'd33);
         @(negedge clk);
         chk($sformatf("v%0d_done_low", i),  64'(done), 64'd0);
         chk($sformatf("v%0d_quot_hold", i), 64'(quot), 64'(vecs[i].q));
         chk($sformatf("v%0d_rem_hold", i),  64'(rem),  64'(vecs[i].r));
      end

      // Start while busy is ignored; start during done launches back-to-back.
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done(4, done_at, busy_cnt, q, r);
      chk("poke_quot",    64'(q),        64'hFFFF_FFFF);
      chk("poke_rem",     64'(r),        64'd0);
      chk("poke_done_at", 64'(done_at),  64'd34);
      chk("poke_busy_n",  64'(busy_cnt), 64'd33);
      start_op(32'd9, 32'd3, 1'b0);
      chk("b2b_busy",      64'(busy), 64'd1);
      chk("b2b_done_low",  64'(done), 64'd0);
      chk("b2b_quot_hold", 64'(quot), 64'hFFFF_FFFF);
      wait_done(-10, done_at, busy_cnt, q, r);
      chk("b2b_quot",    64'(q),       64'd3);
      chk("b2b_rem",     64'(r),       64'd0);
      chk("b2b_done_at", 64'(done_at), 64'd34);
      @(negedge clk);

      // Reset in the middle of CALC abandons the operation.
      start_op(32'd1000, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_quot", 64'(quot), 64'd0);
      chk("rst_rem",  64'(rem),  64'd0);
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk("rst_no_done", 64'(done_seen), 64'd0);
      start_op(32'd50, 32'd5, 1'b0);
      wait_done(-10, done_at, busy_cnt, q, r);
      chk("post_rst_quot",    64'(q),       64'd10);
      chk("post_rst_rem",     64'(r),       64'd0);
      chk("post_rst_done_at", 64'(done_at), 64'd34);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_nios2_div_cell

// File: doc/nios2_div_cell.md
NIOS2_DIV_CELL -- requirements
Module: nios2_div_cell

Interface
REQ-001 Parameter DATA_W, default 32: operand, quotient and remainder width in bits.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port A_div_src1, input, DATA_W: dividend, sampled when a start is accepted.
REQ-005 Port A_div_src2, input, DATA_W: divisor, sampled when a start is accepted.
REQ-006 Port A_div_signed, input, 1: 1 selects two's-complement operands, 0 selects unsigned; sampled when a start is accepted.
REQ-007 Port A_div_start, input, 1: request pulse; accepted only in IDLE.
REQ-008 Port A_div_busy, output, 1: high in CALC and FIX.
REQ-009 Port A_div_done, output, 1: one-cycle completion pulse.
REQ-010 Port A_div_quot, output, DATA_W: quotient.
REQ-011 Port A_div_rem, output, DATA_W: remainder.

Function
REQ-012 States SHALL be IDLE, CALC and FIX.
 - IDLE to CALC: on start.
 - CALC to FIX: when the iteration counter reaches 0.
 - FIX to IDLE: unconditional.
REQ-013 On accept, the cell SHALL latch the operand magnitudes, the quotient sign (signed and src1[MSB] xor src2[MSB]), the remainder sign (signed and src1[MSB]), and load counter = DATA_W-1.
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle, MSB first, for exactly DATA_W cycles.
 - Shift {rem, dividend} left by 1.
 - Trial-subtract the divisor magnitude (DATA_W+1-bit compare).
 - Write the quotient bit.
REQ-015 FIX SHALL negate the quotient if its sign is set and negate the remainder if its sign is set, then register both outputs and raise A_div_done.
REQ-016 Latency: start accepted at edge 0 -> A_div_done high for exactly one cycle after edge DATA_W+2 (edge 34 for DATA_W=32).
REQ-017 A_div_quot and A_div_rem SHALL hold their values from the done cycle until the next FIX completes.
REQ-018 A start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-019 A start asserted in the cycle A_div_done is high SHALL be accepted, giving back-to-back operations.
REQ-020 Divisor zero, detected at accept:
 - CALC still runs DATA_W cycles.
 - FIX bypasses sign fixup.
 - Result: quotient = all ones, remainder = raw src1.
REQ-021 Signed overflow (src1 = most-negative, src2 = -1) SHALL yield quotient = most-negative and remainder = 0, with no special-case logic.
REQ-022 Unsigned divisor larger than dividend SHALL yield quotient = 0 and remainder = dividend.

Reset
REQ-023 reset_n low SHALL immediately force:
 - state IDLE;
 - A_div_busy = 0, A_div_done = 0;
 - A_div_quot = 0, A_div_rem = 0;
 - counter and internal registers = 0.
REQ-024 Reset during CALC or FIX SHALL abandon the operation with no done pulse; the first start after release SHALL behave normally.

Structure
REQ-025 Package nios2_div_pkg SHALL hold the state enum, DATA_W default, and CNT_W = clog2(DATA_W).
REQ-026 One combinational sub-module, nios2_div_step (one restoring iteration: partial remainder, dividend bit and divisor in; new remainder and quotient bit out), SHALL be instantiated once in nios2_div_cell.

Verification
REQ-027 Unsigned 100 / 7 -> quot 14, rem 2; done exactly at edge 34, busy high for edges 1-33.
REQ-028 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quot 0xFFFFFFFD, rem 0xFFFFFFFF; the same operands unsigned -> quot 0x7FFFFFFC, rem 1.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF -> quot 0x80000000, rem 0.
REQ-030 0x12345678 / 0, signed and unsigned -> quot 0xFFFFFFFF, rem 0x12345678, done at edge 34.
REQ-031 Start 0xFFFFFFFF / 1, then re-pulse start at cycle 5 with other operands -> ignored, result quot 0xFFFFFFFF, rem 0; a start in the done cycle launches 9 / 3, giving quot 3, rem 0 after 34 more edges.
REQ-032 reset_n low at cycle 10 of a CALC -> busy, done and outputs 0 at once, no done pulse; after release 50 / 5 -> quot 10, rem 0.
